object_bank: RTL

- Parametrised, multi-channel successor to the single-bit addressable object.
- Holds CHANNELS DATA_W-bit status registers, each decoded at a consecutive address starting at BASE_ADDR.
- Accepts commands over a valid/ready request port: write, set, clear, toggle, read, timed pulse and pulse-length configuration.
- Returns one response per accepted request; sits on the shared command bus next to other object-class peripherals.

---
 rtl/object_pkg.sv | 25 ++
 rtl/object_pulse_timer.sv | 31 +++
 rtl/object_bank.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/object_pkg.sv
// Shared types and constants for the object-class peripherals.
package object_pkg;

  typedef enum logic [2:0] {
    OP_WRITE  = 3'd0,
    OP_SET    = 3'd1,
    OP_CLR    = 3'd2,
    OP_TOG    = 3'd3,
    OP_READ   = 3'd4,
    OP_PULSE  = 3'd5,
    OP_SETLEN = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  // Data field sized for the widest supported bank; banks use the low DATA_W bits.
  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic                  err;
  } rsp_t;

  localparam int LEN_RESET = 1;

endpackage

// File: rtl/object_pulse_timer.sv
// Per-channel pulse down-counter; expire marks the cycle the count reaches zero.
module object_pulse_timer #(
  parameter int PULSE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cancel,
  input  logic [PULSE_W-1:0] len,
  output logic               active,
  output logic               expire
);

  logic [PULSE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cancel) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign active = (cnt != '0);
  assign expire = (cnt == PULSE_W'(1));

endmodule

// File: rtl/object_bank.sv
// Bank of CHANNELS addressable status registers with per-channel timed pulses,
// driven over a valid/ready command port with one registered response per request.
module object_bank
  import object_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 1,
  parameter int CHANNELS  = 4,
  parameter int DATA_W    = 8,
  parameter int PULSE_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [2:0]                   req_op_i,
  input  logic [DATA_W-1:0]            req_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_W-1:0]            rsp_data_o,
  output logic                         rsp_err_o,
  output logic [CHANNELS*DATA_W-1:0]   status_o,
  output logic [CHANNELS-1:0]          pulse_active_o
);

  localparam int ADDR_END = BASE_ADDR + CHANNELS;

  logic [DATA_W-1:0]  status_q [CHANNELS];
  logic [DATA_W-1:0]  status_d [CHANNELS];
  logic [DATA_W-1:0]  mask_q   [CHANNELS];
  logic [DATA_W-1:0]  mask_d   [CHANNELS];
  logic [PULSE_W-1:0] len_q    [CHANNELS];
  logic [PULSE_W-1:0] len_d    [CHANNELS];

  logic [CHANNELS-1:0] start, cancel, active, expire;
  logic                accept, hit, busy, err;
  int                  ch;
  op_e                 op;
  logic [DATA_W-1:0]   cur, nxt;
  rsp_t                rsp_n;
  logic                unused_rsp;

  assign req_ready_o    = !rsp_valid_o || rsp_ready_i;
  assign accept         = req_valid_i && req_ready_o;
  assign op             = op_e'(req_op_i);
  assign pulse_active_o = active;
  assign unused_rsp     = ^rsp_n.data;

  always_comb begin
    ch   = int'(req_addr_i) - BASE_ADDR;
    hit  = (int'(req_addr_i) >= BASE_ADDR) && (int'(req_addr_i) < ADDR_END);
    cur  = '0;
    busy = 1'b0;
    // Expiry clears first, so a same-cycle command sees the cleared value and an idle channel.
    for (int k = 0; k < CHANNELS; k++) begin
      status_d[k] = expire[k] ? (status_q[k] & ~mask_q[k]) : status_q[k];
      mask_d[k]   = expire[k] ? '0 : mask_q[k];
      len_d[k]    = len_q[k];
      if (hit && (k == ch)) begin
        cur  = expire[k] ? (status_q[k] & ~mask_q[k]) : status_q[k];
        busy = active[k] && !expire[k];
      end
    end

    err = !hit || (op == OP_RSVD) || ((op == OP_PULSE) && busy);

    case (op)
      OP_WRITE:           nxt = req_data_i;
      OP_SET, OP_PULSE:   nxt = cur | req_data_i;
      OP_CLR:             nxt = cur & ~req_data_i;
      OP_TOG:             nxt = cur ^ req_data_i;
      default:            nxt = cur;
    endcase

    start  = '0;
    cancel = '0;
    if (accept && !err) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (k == ch) begin
          status_d[k] = nxt;
          case (op)
            OP_WRITE: begin
              mask_d[k] = '0;
              cancel[k] = 1'b1;
            end
            OP_PULSE: begin
              mask_d[k] = req_data_i;
              start[k]  = 1'b1;
            end
            OP_SETLEN: len_d[k] = (req_data_i[PULSE_W-1:0] == '0) ? PULSE_W'(LEN_RESET)
                                                                  : req_data_i[PULSE_W-1:0];
            default: ;
          endcase
        end
      end
    end

    rsp_n     = '0;
    rsp_n.err = err;
    if (!err) rsp_n.data[DATA_W-1:0] = nxt;
  end

  // Register stage: status/pulse state and the held response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        status_q[k] <= '0;
        mask_q[k]   <= '0;
        len_q[k]    <= PULSE_W'(LEN_RESET);
      end
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        status_q[k] <= status_d[k];
        mask_q[k]   <= mask_d[k];
        len_q[k]    <= len_d[k];
      end
      if (accept) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= rsp_n.data[DATA_W-1:0];
        rsp_err_o   <= rsp_n.err;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign status_o[g*DATA_W +: DATA_W] = status_q[g];

    object_pulse_timer #(.PULSE_W(PULSE_W)) u_timer (
      .clk    (clk_i),
      .rst    (rst_i),
      .start  (start[g]),
      .cancel (cancel[g]),
      .len    (len_q[g]),
      .active (active[g]),
      .expire (expire[g])
    );
  end

endmodule
